ysyx_25040109_ifu: RTL and testbench

YSYX_25040109_IFU -- requirements
Module: ysyx_25040109_ifu

---
 rtl/ysyx_25040109_ifu.sv | 112 +++++++++++
 tb/tb_ysyx_25040109_ifu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, holding each instruction
// until the decoder takes it, with downstream redirects overriding any other event.
module ysyx_25040109_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_pc_s;

  assign redir_pc_s = redirect_pc & 32'hFFFF_FFFC;

  // State, pc and instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0000;
      inst_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state logic; a redirect wins over handshakes and responses in every state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // A consume coinciding with a redirect still takes the redirect target
        if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else begin
          pc_d = pc_q;
        end
        state_d = imem_resp_valid ? S_REQ : S_DROP;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Directed bench for the fetch unit: a one-outstanding memory model, a pc-stream
// scoreboard checked every cycle, and literal expectations for the key scenarios.
module tb_ysyx_25040109_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory model state and knobs
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_wait = 0;
  int          mem_lat = 1;
  logic        force_resp = 1'b0;

  // scoreboard: address the decoder must see next
  logic [31:0] exp_pc = RESET_PC;

  always #5 clk = ~clk;

  ysyx_25040109_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive();
    if (force_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
    end else if (mem_pend && mem_wait == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // advance one clock; the memory reacts to the handshakes seen at that edge
  task automatic cyc();
    logic acc, rsp, rs;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid & imem_req_ready;
    rsp = imem_resp_valid;
    rs  = rst;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (rs) begin
      mem_pend = 1'b0;
    end else begin
      if (rsp) mem_pend = 1'b0;
      if (acc) begin
        mem_pend = 1'b1;
        mem_addr = a;
        mem_wait = mem_lat - 1;
      end else if (mem_pend && mem_wait > 0) begin
        mem_wait--;
      end
    end
    drive();
  endtask

  task automatic wait_inst(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (inst_valid) break;
      cyc();
    end
    chk(name, {31'b0, inst_valid}, 32'd1);
  endtask

  // scoreboard: every cycle check outputs against the expected pc stream
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = RESET_PC;
      end else begin
        chk("req_inst_exclusive", {31'b0, imem_req_valid & inst_valid}, 32'd0);
        if (imem_req_valid) begin
          chk("sb_req_addr", imem_req_addr, exp_pc);
          chk("sb_one_outstanding", {31'b0, mem_pend}, 32'd0);
        end
        if (inst_valid) begin
          chk("sb_inst_pc", inst_pc, exp_pc);
          chk("sb_inst_word", inst, word(exp_pc));
        end
        if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b1;
    drive();
    cyc(); cyc();
    rst = 1'b0;

    // basic fetch with minimum latency
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    cyc();
    chk("c2_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    chk("c3_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("c3_inst", inst, 32'h0000_0413);
    chk("c3_inst_pc", inst_pc, 32'h8000_0000);
    cyc();
    chk("c4_req_addr", imem_req_addr, 32'h8000_0004);
    chk("c4_inst_valid", {31'b0, inst_valid}, 32'd0);

    // decoder stalls for five cycles
    inst_ready = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h43C3_0004);
      chk("hold_pc", inst_pc, 32'h8000_0004);
      chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      cyc();
    end
    chk("hold_still", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    cyc();
    chk("after_hold_addr", imem_req_addr, 32'h8000_0008);

    // redirect while waiting, late response dropped
    mem_lat = 3;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    cyc();
    redirect_valid = 1'b0;
    chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    chk("drop_late_resp", {31'b0, imem_resp_valid}, 32'd1);
    chk("drop_no_inst", {31'b0, inst_valid}, 32'd0);
    cyc();
    chk("drop_req_addr", imem_req_addr, 32'h8000_0100);
    chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
    mem_lat = 1;
    wait_inst("redir_fetch_timeout", 10);
    chk("redir_inst_pc", inst_pc, 32'h8000_0100);

    // redirect in HOLD together with a consume
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    cyc();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'b0, inst_valid}, 32'd0);
    chk("hold_redir_addr", imem_req_addr, 32'h8000_0040);

    // redirect in WAIT with same-cycle response
    cyc();
    chk("wait_resp_present", {31'b0, imem_resp_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h9000_0003;
    cyc();
    redirect_valid = 1'b0;
    chk("wr_req_addr", imem_req_addr, 32'h9000_0000);
    chk("wr_inst_valid", {31'b0, inst_valid}, 32'd0);

    // redirect in REQ with handshake, then without
    redirect_valid = 1'b1; redirect_pc = 32'h9000_0010;
    cyc();
    redirect_valid = 1'b0;
    chk("rq_drop", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    chk("rq_addr", imem_req_addr, 32'h9000_0010);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("rq_nohs_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("rq_nohs_valid", {31'b0, imem_req_valid}, 32'd1);

    // pc wrap
    imem_req_ready = 1'b1;
    wait_inst("wrap_fetch_timeout", 10);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // reset during WAIT, then a stale response in REQ
    mem_lat = 3;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("mid_rst_addr", imem_req_addr, RESET_PC);
    imem_req_ready = 1'b0; force_resp = 1'b1;
    drive();
    cyc();
    force_resp = 1'b0;
    drive();
    chk("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("stale_addr", imem_req_addr, RESET_PC);
    chk("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
    imem_req_ready = 1'b1; mem_lat = 1;
    wait_inst("post_rst_timeout", 10);
    chk("post_rst_inst", inst, 32'h0000_0413);
    cyc(); cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
